// File: rtl/riscv_mem_pkg.sv
// Shared types for the two-master memory arbiter.
//   arb_state_t : arbiter FSM state (IDLE / BUSY)
//   mem_req_t   : one memory request payload (write enable, byte enables,
//                 byte address, write data); used both for the master input
//                 bundles and for the latched payload register
package riscv_mem_pkg;

    localparam int NUM_MASTERS = 2;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

    typedef struct packed {
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wd;
    } mem_req_t;

endpackage

// File: rtl/riscv_rr_picker.sv
// Combinational 2-way round-robin select.
//   req   in  [1:0]  request vector, bit N = master N
//   prio  in  1      master favoured when both request
//   valid out 1      at least one request present
//   idx   out 1      index of the winning master
module riscv_rr_picker
    import riscv_mem_pkg::*;
(
    input  logic [NUM_MASTERS-1:0] req,
    input  logic                   prio,
    output logic                   valid,
    output logic                   idx
);

    assign valid = |req;
    // A lone requester wins outright; on contention the favoured one wins.
    assign idx   = (&req) ? prio : req[1];

endmodule

// File: rtl/riscv_mem_arbiter.sv
// Two-master round-robin arbiter in front of a single memory port.
// Master 0 is instruction fetch, master 1 is the LSU. The winning request is
// latched, held on the memory port until mem_ready_i (or watchdog expiry),
// and the completion is routed back to the granted master combinationally.
//
// Parameters:
//   TIMEOUT_CYCLES  BUSY cycles without mem_ready_i before a forced error
//                   completion; 0 disables the watchdog.
// Ports:
//   clk_i, rst_ni                        clock, async active-low reset
//   mN_req_i/we_i/be_i/addr_i/wd_i       master N request + payload (N=0,1)
//   mN_rd_o/ready_o/err_o                master N read data, done pulse, error
//   mem_req_o/we_o/be_o/addr_o/wd_o      memory request + latched payload
//   mem_rd_i, mem_ready_i                memory read data, done pulse
module riscv_mem_arbiter
    import riscv_mem_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk_i,
    input  logic        rst_ni,

    input  logic        m0_req_i,
    input  logic        m0_we_i,
    input  logic [3:0]  m0_be_i,
    input  logic [31:0] m0_addr_i,
    input  logic [31:0] m0_wd_i,
    output logic [31:0] m0_rd_o,
    output logic        m0_ready_o,
    output logic        m0_err_o,

    input  logic        m1_req_i,
    input  logic        m1_we_i,
    input  logic [3:0]  m1_be_i,
    input  logic [31:0] m1_addr_i,
    input  logic [31:0] m1_wd_i,
    output logic [31:0] m1_rd_o,
    output logic        m1_ready_o,
    output logic        m1_err_o,

    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wd_o,
    input  logic [31:0] mem_rd_i,
    input  logic        mem_ready_i
);

    localparam int CNT_W = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

    arb_state_t                state_q;
    logic                      grant_q;
    logic                      prio_q;
    mem_req_t                  payload_q;
    logic [CNT_W-1:0]          cnt_q;

    logic [NUM_MASTERS-1:0]    req;
    mem_req_t                  m0_bundle;
    mem_req_t                  m1_bundle;
    logic                      pick_valid;
    logic                      pick_idx;
    logic                      busy;
    logic                      expire;
    logic                      done;
    logic [31:0]               rd_ret;

    assign req       = {m1_req_i, m0_req_i};
    assign m0_bundle = {m0_we_i, m0_be_i, m0_addr_i, m0_wd_i};
    assign m1_bundle = {m1_we_i, m1_be_i, m1_addr_i, m1_wd_i};
    assign busy      = (state_q == BUSY);

    riscv_rr_picker u_picker (
        .req   (req),
        .prio  (prio_q),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    // Watchdog fires on the TIMEOUT_CYCLES-th BUSY cycle; a coincident
    // mem_ready_i wins and yields a normal completion instead.
    if (TIMEOUT_CYCLES == 0) begin : g_no_watchdog
        assign expire = 1'b0;
    end else begin : g_watchdog
        assign expire = busy && !mem_ready_i &&
                        (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
    end

    assign done   = busy && (mem_ready_i || expire);
    assign rd_ret = mem_ready_i ? mem_rd_i : 32'h0;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            grant_q   <= 1'b0;
            prio_q    <= 1'b0;
            payload_q <= '0;
            cnt_q     <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pick_valid) begin
                        state_q   <= BUSY;
                        grant_q   <= pick_idx;
                        payload_q <= pick_idx ? m1_bundle : m0_bundle;
                        cnt_q     <= '0;
                    end
                end
                BUSY: begin
                    if (done) begin
                        state_q <= IDLE;
                        prio_q  <= ~grant_q;
                    end else if (cnt_q != '1) begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Memory side: payload is only presented while BUSY.
    assign mem_req_o  = busy;
    assign mem_we_o   = busy & payload_q.we;
    assign mem_be_o   = busy ? payload_q.be   : 4'h0;
    assign mem_addr_o = busy ? payload_q.addr : 32'h0;
    assign mem_wd_o   = busy ? payload_q.wd   : 32'h0;

    // Return path: only the granted master ever sees a non-zero output.
    // NOTE: every output gets a default before the conditional updates so no
    // path through this block leaves a value unassigned (no latches).
    always_comb begin
        m0_ready_o = 1'b0;
        m0_err_o   = 1'b0;
        m0_rd_o    = 32'h0;
        m1_ready_o = 1'b0;
        m1_err_o   = 1'b0;
        m1_rd_o    = 32'h0;
        if (done) begin
            if (grant_q) begin
                m1_ready_o = 1'b1;
                m1_err_o   = expire;
                m1_rd_o    = rd_ret;
            end else begin
                m0_ready_o = 1'b1;
                m0_err_o   = expire;
                m0_rd_o    = rd_ret;
            end
        end
    end

endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// Self-checking bench for riscv_mem_arbiter (watchdog set to 4 cycles).
// A transaction-level reference model tracks whether a transfer is
// outstanding, who owns it, how long it has waited and who is favoured next;
// every cycle all DUT outputs are compared against it. Directed scenarios
// add explicit constant checks, then a randomized phase runs.
module tb_riscv_mem_arbiter;
    import riscv_mem_pkg::*;

    localparam int TO = 4;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;

    logic        m0_req_i, m0_we_i;
    logic [3:0]  m0_be_i;
    logic [31:0] m0_addr_i, m0_wd_i, m0_rd_o;
    logic        m0_ready_o, m0_err_o;
    logic        m1_req_i, m1_we_i;
    logic [3:0]  m1_be_i;
    logic [31:0] m1_addr_i, m1_wd_i, m1_rd_o;
    logic        m1_ready_o, m1_err_o;
    logic        mem_req_o, mem_we_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_addr_o, mem_wd_o;
    logic [31:0] mem_rd_i;
    logic        mem_ready_i;

    always #5 clk_i = ~clk_i;

    riscv_mem_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .m0_req_i    (m0_req_i),
        .m0_we_i     (m0_we_i),
        .m0_be_i     (m0_be_i),
        .m0_addr_i   (m0_addr_i),
        .m0_wd_i     (m0_wd_i),
        .m0_rd_o     (m0_rd_o),
        .m0_ready_o  (m0_ready_o),
        .m0_err_o    (m0_err_o),
        .m1_req_i    (m1_req_i),
        .m1_we_i     (m1_we_i),
        .m1_be_i     (m1_be_i),
        .m1_addr_i   (m1_addr_i),
        .m1_wd_i     (m1_wd_i),
        .m1_rd_o     (m1_rd_o),
        .m1_ready_o  (m1_ready_o),
        .m1_err_o    (m1_err_o),
        .mem_req_o   (mem_req_o),
        .mem_we_o    (mem_we_o),
        .mem_be_o    (mem_be_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wd_o    (mem_wd_o),
        .mem_rd_i    (mem_rd_i),
        .mem_ready_i (mem_ready_i)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] observed,
                         input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // ---------------- reference model ----------------
    bit       mdl_busy;     // a transfer is outstanding on the memory port
    bit       mdl_owner;    // which master owns it
    bit       mdl_favour;   // master that wins the next tie
    mem_req_t mdl_pl;       // payload captured when the transfer started
    int       mdl_waited;   // BUSY cycles already spent on this transfer
    bit       last_ready[2];
    int       order_q[$];

    task automatic model_reset();
        mdl_busy      = 1'b0;
        mdl_owner     = 1'b0;
        mdl_favour    = 1'b0;
        mdl_pl        = '0;
        mdl_waited    = 0;
        last_ready[0] = 1'b0;
        last_ready[1] = 1'b0;
    endtask

    // Called at posedge+1 with inputs applied: compares at posedge+4 and
    // advances the model by one clock.
    task automatic tick();
        mem_req_t    in0, in1;
        bit          timed_out, finished, win;
        logic [31:0] exp_rd;
        #3;
        in0       = {m0_we_i, m0_be_i, m0_addr_i, m0_wd_i};
        in1       = {m1_we_i, m1_be_i, m1_addr_i, m1_wd_i};
        timed_out = mdl_busy && (mdl_waited + 1 == TO) && !mem_ready_i;
        finished  = mdl_busy && (mem_ready_i || timed_out);
        exp_rd    = (finished && mem_ready_i) ? mem_rd_i : 32'h0;

        check("mem_req",  32'(mem_req_o),  32'(mdl_busy));
        check("mem_we",   32'(mem_we_o),   mdl_busy ? 32'(mdl_pl.we) : 32'h0);
        check("mem_be",   32'(mem_be_o),   mdl_busy ? 32'(mdl_pl.be) : 32'h0);
        check("mem_addr", mem_addr_o,      mdl_busy ? mdl_pl.addr : 32'h0);
        check("mem_wd",   mem_wd_o,        mdl_busy ? mdl_pl.wd   : 32'h0);
        check("m0_ready", 32'(m0_ready_o), 32'(finished  && !mdl_owner));
        check("m0_err",   32'(m0_err_o),   32'(timed_out && !mdl_owner));
        check("m0_rd",    m0_rd_o,         !mdl_owner ? exp_rd : 32'h0);
        check("m1_ready", 32'(m1_ready_o), 32'(finished  && mdl_owner));
        check("m1_err",   32'(m1_err_o),   32'(timed_out && mdl_owner));
        check("m1_rd",    m1_rd_o,         mdl_owner ? exp_rd : 32'h0);

        if (m0_ready_o) order_q.push_back(0);
        if (m1_ready_o) order_q.push_back(1);
        last_ready[0] = finished && !mdl_owner;
        last_ready[1] = finished && mdl_owner;

        if (mdl_busy) begin
            if (finished) begin
                mdl_busy   = 1'b0;
                mdl_favour = !mdl_owner;
            end else begin
                mdl_waited++;
            end
        end else if (m0_req_i || m1_req_i) begin
            win        = (m0_req_i && m1_req_i) ? mdl_favour : m1_req_i;
            mdl_owner  = win;
            mdl_pl     = win ? in1 : in0;
            mdl_busy   = 1'b1;
            mdl_waited = 0;
        end
    endtask

    task automatic next();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_mem_req"},  32'(mem_req_o),  32'h0);
        check({tag, "_mem_we"},   32'(mem_we_o),   32'h0);
        check({tag, "_mem_be"},   32'(mem_be_o),   32'h0);
        check({tag, "_mem_addr"}, mem_addr_o,      32'h0);
        check({tag, "_mem_wd"},   mem_wd_o,        32'h0);
        check({tag, "_m0_ready"}, 32'(m0_ready_o), 32'h0);
        check({tag, "_m0_err"},   32'(m0_err_o),   32'h0);
        check({tag, "_m0_rd"},    m0_rd_o,         32'h0);
        check({tag, "_m1_ready"}, 32'(m1_ready_o), 32'h0);
        check({tag, "_m1_err"},   32'(m1_err_o),   32'h0);
        check({tag, "_m1_rd"},    m1_rd_o,         32'h0);
    endtask

    logic [7:0] pattern;

    initial begin
        m0_req_i = 0; m0_we_i = 0; m0_be_i = 0; m0_addr_i = 0; m0_wd_i = 0;
        m1_req_i = 0; m1_we_i = 0; m1_be_i = 0; m1_addr_i = 0; m1_wd_i = 0;
        mem_rd_i = 0; mem_ready_i = 0;
        model_reset();

        // ---- reset state ----
        #12;
        check_all_zero("rst");
        @(negedge clk_i);
        rst_ni = 1'b1;
        next();

        // ---- lone master 1 read, memory ready in cycle 3 ----
        m1_req_i = 1; m1_we_i = 0; m1_be_i = 4'hF; m1_addr_i = 32'h100;
        tick(); check("t1_c0_req", 32'(mem_req_o), 32'h0); next();
        tick(); check("t1_c1_req", 32'(mem_req_o), 32'h1);
        check("t1_c1_addr", mem_addr_o, 32'h100); next();
        tick(); check("t1_c2_req", 32'(mem_req_o), 32'h1); next();
        mem_ready_i = 1; mem_rd_i = 32'hCAFEBABE;
        tick();
        check("t1_c3_req", 32'(mem_req_o), 32'h1);
        check("t1_m1_ready", 32'(m1_ready_o), 32'h1);
        check("t1_m1_rd", m1_rd_o, 32'hCAFEBABE);
        check("t1_m0_ready", 32'(m0_ready_o), 32'h0);
        check("t1_m0_rd", m0_rd_o, 32'h0);
        next();
        mem_ready_i = 0; mem_rd_i = 0; m1_req_i = 0;
        tick(); check("t1_c4_req", 32'(mem_req_o), 32'h0); next();

        // ---- both masters continuously, memory answers on first BUSY cycle ----
        m0_req_i = 1; m0_we_i = 0; m0_be_i = 4'hF; m0_addr_i = 32'h1000;
        m1_req_i = 1; m1_we_i = 0; m1_be_i = 4'hF; m1_addr_i = 32'h2000;
        order_q.delete();
        for (int c = 0; c < 8; c++) begin
            mem_ready_i = mdl_busy;
            mem_rd_i    = $urandom;
            tick();
            pattern[c] = mem_req_o;
            next();
        end
        check("t2_req_pattern", 32'(pattern), 32'h000000AA);
        check("t2_n_grants", order_q.size(), 32'd4);
        if (order_q.size() >= 4) begin
            check("t2_grant0", order_q[0], 32'd0);
            check("t2_grant1", order_q[1], 32'd1);
            check("t2_grant2", order_q[2], 32'd0);
            check("t2_grant3", order_q[3], 32'd1);
        end
        m0_req_i = 0; m1_req_i = 0; mem_ready_i = 0;
        tick(); next();

        // ---- master 0 write, payload frozen while BUSY ----
        m0_req_i = 1; m0_we_i = 1; m0_be_i = 4'b0011;
        m0_addr_i = 32'h200; m0_wd_i = 32'h00001234;
        tick(); next();
        for (int c = 1; c <= 3; c++) begin
            m0_addr_i   = $urandom;
            m0_wd_i     = $urandom;
            mem_ready_i = (c == 3);
            tick();
            check("t3_addr", mem_addr_o, 32'h200);
            check("t3_wd", mem_wd_o, 32'h00001234);
            check("t3_be", 32'(mem_be_o), 32'h3);
            check("t3_we", 32'(mem_we_o), 32'h1);
            check("t3_ready", 32'(m0_ready_o), 32'(c == 3));
            next();
        end
        m0_req_i = 0; m0_we_i = 0; mem_ready_i = 0;
        tick(); next();

        // ---- watchdog expiry, memory never ready ----
        m0_req_i = 1; m0_addr_i = 32'h300; mem_rd_i = 32'h5A5A5A5A;
        tick(); next();
        for (int c = 1; c <= 3; c++) begin
            tick(); check("t4_no_ready", 32'(m0_ready_o), 32'h0); next();
        end
        tick();
        check("t4_ready", 32'(m0_ready_o), 32'h1);
        check("t4_err", 32'(m0_err_o), 32'h1);
        check("t4_rd", m0_rd_o, 32'h0);
        next();
        m0_req_i = 0; mem_ready_i = 1;
        tick();
        check("t4_req_after", 32'(mem_req_o), 32'h0);
        check("t4_late_ready", 32'(m0_ready_o), 32'h0);
        next();
        mem_ready_i = 0;
        tick(); next();

        // ---- memory ready exactly in the expiry cycle ----
        m0_req_i = 1; m0_addr_i = 32'h340;
        tick(); next();
        for (int c = 1; c <= 3; c++) begin
            tick(); next();
        end
        mem_ready_i = 1; mem_rd_i = 32'h12345678;
        tick();
        check("t5_ready", 32'(m0_ready_o), 32'h1);
        check("t5_err", 32'(m0_err_o), 32'h0);
        check("t5_rd", m0_rd_o, 32'h12345678);
        next();
        m0_req_i = 0; mem_ready_i = 0;
        tick(); next();

        // ---- asynchronous reset mid-BUSY (master 1 favoured beforehand) ----
        m1_req_i = 1; m1_addr_i = 32'h400;
        tick(); next();
        tick(); next();
        #2;
        rst_ni = 1'b0;
        #1;
        check_all_zero("t6_async");
        model_reset();
        @(negedge clk_i);
        check("t6_no_pulse", 32'(m1_ready_o), 32'h0);
        m1_req_i = 0;
        @(negedge clk_i);
        rst_ni = 1'b1;
        next();
        m0_req_i = 1; m0_addr_i = 32'h500; m0_we_i = 0;
        m1_req_i = 1; m1_addr_i = 32'h600; m1_we_i = 0;
        tick(); next();
        mem_ready_i = 1; mem_rd_i = 32'h0BADF00D;
        tick();
        check("t6_winner_addr", mem_addr_o, 32'h500);
        check("t6_m0_ready", 32'(m0_ready_o), 32'h1);
        next();
        m0_req_i = 0; m1_req_i = 0; mem_ready_i = 0;
        tick(); next();

        // ---- randomized traffic ----
        for (int c = 0; c < 600; c++) begin
            if (last_ready[0] || !m0_req_i) begin
                m0_req_i  = ($urandom_range(0, 1) == 1);
                m0_we_i   = 1'($urandom);
                m0_be_i   = 4'($urandom);
                m0_addr_i = $urandom;
                m0_wd_i   = $urandom;
            end
            if (last_ready[1] || !m1_req_i) begin
                m1_req_i  = ($urandom_range(0, 1) == 1);
                m1_we_i   = 1'($urandom);
                m1_be_i   = 4'($urandom);
                m1_addr_i = $urandom;
                m1_wd_i   = $urandom;
            end
            mem_ready_i = ($urandom_range(0, 2) == 0);
            mem_rd_i    = $urandom;
            tick();
            next();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
